// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution MAC controller.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    MAC,
    DRAIN,
    SETTLE,
    WRITE,
    DONE
  } state_e;

  // Weight SRAM word holding the bias; kernel taps follow it.
  localparam int unsigned BIAS_WADDR = 0;

  // Output width/height for a valid-padding, stride-1 convolution.
  function automatic int unsigned out_w(input int unsigned in_w, input int unsigned ksize);
    return in_w - ksize + 1;
  endfunction

  // Number of kernel taps streamed per output pixel.
  function automatic int unsigned n_taps(input int unsigned cin, input int unsigned ksize);
    return cin * ksize * ksize;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Tap and pixel counter nest producing fmap, weight and output addresses
// incrementally (adders only, no multipliers).
module conv_addr_gen
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned KSIZE = 3,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned FA_W  = 12,
  parameter int unsigned WA_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            next_pixel,
  input  logic [4:0]      cin_m1,
  output logic [FA_W-1:0] fmap_addr,
  output logic [WA_W-1:0] wgt_addr,
  output logic [FA_W-1:0] out_addr,
  output logic            last_tap,
  output logic            last_pixel
);

  localparam int unsigned OUT_W     = out_w(IN_W, KSIZE);
  localparam int unsigned K_W       = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int unsigned O_W       = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  // Jump from the last column of a kernel row to the first of the next row.
  localparam int unsigned ROW_STEP  = IN_W - (KSIZE - 1);
  // Jump from the last tap of a channel window to the first tap of the next channel.
  localparam int unsigned CH_STEP   = IN_W * IN_W - (KSIZE - 1) * IN_W - (KSIZE - 1);
  // Window origin advance when ox wraps to the next output row.
  localparam int unsigned WRAP_STEP = KSIZE;

  logic [K_W-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic [4:0]      ci_q, ci_d;
  logic [O_W-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic            bias_q, bias_d;
  logic [FA_W-1:0] fmap_q, fmap_d, base_q, base_d, out_q, out_d;
  logic [WA_W-1:0] wgt_q, wgt_d;
  logic            kx_end, ky_end, ox_end;

  assign kx_end     = (kx_q == K_W'(KSIZE - 1));
  assign ky_end     = (ky_q == K_W'(KSIZE - 1));
  assign ox_end     = (ox_q == O_W'(OUT_W - 1));
  assign last_tap   = !bias_q && kx_end && ky_end && (ci_q == cin_m1);
  assign last_pixel = ox_end && (oy_q == O_W'(OUT_W - 1));

  assign fmap_addr = fmap_q;
  assign wgt_addr  = wgt_q;
  assign out_addr  = out_q;

  // Counter nest: bias slot first, then kx fastest, ky, ci; pixels ox fastest.
  always_comb begin
    kx_d   = kx_q;
    ky_d   = ky_q;
    ci_d   = ci_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    bias_d = bias_q;
    fmap_d = fmap_q;
    base_d = base_q;
    out_d  = out_q;
    wgt_d  = wgt_q;
    if (load) begin
      kx_d   = '0;
      ky_d   = '0;
      ci_d   = '0;
      ox_d   = '0;
      oy_d   = '0;
      bias_d = 1'b1;
      fmap_d = '0;
      base_d = '0;
      out_d  = '0;
      wgt_d  = WA_W'(BIAS_WADDR);
    end else if (next_pixel) begin
      kx_d   = '0;
      ky_d   = '0;
      ci_d   = '0;
      bias_d = 1'b1;
      wgt_d  = WA_W'(BIAS_WADDR);
      out_d  = out_q + FA_W'(1);
      if (ox_end) begin
        ox_d   = '0;
        oy_d   = oy_q + O_W'(1);
        base_d = base_q + FA_W'(WRAP_STEP);
      end else begin
        ox_d   = ox_q + O_W'(1);
        base_d = base_q + FA_W'(1);
      end
      fmap_d = base_d;
    end else if (step) begin
      wgt_d = wgt_q + WA_W'(1);
      if (bias_q) begin
        bias_d = 1'b0;
      end else if (!kx_end) begin
        kx_d   = kx_q + K_W'(1);
        fmap_d = fmap_q + FA_W'(1);
      end else if (!ky_end) begin
        kx_d   = '0;
        ky_d   = ky_q + K_W'(1);
        fmap_d = fmap_q + FA_W'(ROW_STEP);
      end else begin
        kx_d   = '0;
        ky_d   = '0;
        ci_d   = ci_q + 5'd1;
        fmap_d = fmap_q + FA_W'(CH_STEP);
      end
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      kx_q   <= '0;
      ky_q   <= '0;
      ci_q   <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      bias_q <= 1'b1;
      fmap_q <= '0;
      base_q <= '0;
      out_q  <= '0;
      wgt_q  <= '0;
    end else begin
      kx_q   <= kx_d;
      ky_q   <= ky_d;
      ci_q   <= ci_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      bias_q <= bias_d;
      fmap_q <= fmap_d;
      base_q <= base_d;
      out_q  <= out_d;
      wgt_q  <= wgt_d;
    end
  end

endmodule

// File: rtl/conv_mac_ctrl.sv
// Sequences one MAC through a single-output-channel valid-padding convolution:
// clear, bias add, tap stream, result capture and ready/valid write per pixel.
module conv_mac_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned KSIZE   = 3,
  parameter int unsigned IN_W    = 8,
  parameter int unsigned MAX_CIN = 16,
  parameter int unsigned FA_W    = 12,
  parameter int unsigned WA_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      cfg_cin,
  output logic            busy,
  output logic            done,
  output logic [FA_W-1:0] fmap_addr,
  output logic [WA_W-1:0] wgt_addr,
  output logic            mac_rstn,
  output logic            mac_en,
  output logic            mac_only_add,
  input  logic [7:0]      mac_dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic [FA_W-1:0] out_addr
);

  localparam int unsigned CIN_W = 5;

  state_e           state_q, state_d;
  logic [CIN_W-1:0] cin_m1_q, cin_m1_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             mac_en_q, mac_en_d, only_add_q, only_add_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             clr_strobe, issue_bias, issue_tap;
  logic             ag_load, ag_step, ag_next, last_tap, last_pixel;

  conv_addr_gen #(
    .KSIZE(KSIZE),
    .IN_W (IN_W),
    .FA_W (FA_W),
    .WA_W (WA_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .step      (ag_step),
    .next_pixel(ag_next),
    .cin_m1    (cin_m1_q),
    .fmap_addr (fmap_addr),
    .wgt_addr  (wgt_addr),
    .out_addr  (out_addr),
    .last_tap  (last_tap),
    .last_pixel(last_pixel)
  );

  // The accumulator clear must coincide with the CLR cycle, so this stays combinational.
  assign mac_rstn = ~(rst | clr_strobe);

  assign busy         = busy_q;
  assign done         = done_q;
  assign mac_en       = mac_en_q;
  assign mac_only_add = only_add_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;

  // Next-state, address-generator controls and registered-output next values.
  always_comb begin
    state_d    = state_q;
    cin_m1_d   = cin_m1_q;
    out_data_d = out_data_q;
    ag_load    = 1'b0;
    ag_step    = 1'b0;
    ag_next    = 1'b0;
    clr_strobe = 1'b0;
    issue_bias = 1'b0;
    issue_tap  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ag_load = 1'b1;
          state_d = CLR;
          if (cfg_cin == '0) begin
            cin_m1_d = '0;
          end else if (32'(cfg_cin) > MAX_CIN) begin
            cin_m1_d = CIN_W'(MAX_CIN - 1);
          end else begin
            cin_m1_d = cfg_cin - CIN_W'(1);
          end
        end
      end
      CLR: begin
        clr_strobe = 1'b1;
        issue_bias = 1'b1;
        ag_step    = 1'b1;
        state_d    = MAC;
      end
      MAC: begin
        issue_tap = 1'b1;
        if (last_tap) begin
          state_d = DRAIN;
        end else begin
          ag_step = 1'b1;
        end
      end
      DRAIN: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        out_data_d = mac_dout;
        state_d    = WRITE;
      end
      WRITE: begin
        if (out_ready) begin
          if (last_pixel) begin
            state_d = DONE;
          end else begin
            ag_next = 1'b1;
            state_d = CLR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Issue strobes are delayed one cycle so they meet the SRAM read data.
    mac_en_d    = issue_bias | issue_tap;
    only_add_d  = issue_bias;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    out_valid_d = (state_d == WRITE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cin_m1_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      only_add_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cin_m1_q    <= cin_m1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mac_en_q    <= mac_en_d;
      only_add_q  <= only_add_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed bench for conv_mac_ctrl with SRAM and MAC behavioural models.
module tb_conv_mac_ctrl;

  localparam int unsigned KSIZE   = 3;
  localparam int unsigned IN_W    = 4;
  localparam int unsigned MAX_CIN = 16;
  localparam int unsigned FA_W    = 12;
  localparam int unsigned WA_W    = 8;

  logic            clk = 1'b0;
  logic            rst, start, out_ready;
  logic [4:0]      cfg_cin;
  logic            busy, done, mac_rstn, mac_en, mac_only_add, out_valid;
  logic [FA_W-1:0] fmap_addr, out_addr;
  logic [WA_W-1:0] wgt_addr;
  logic [7:0]      mac_dout, out_data;

  always #5 clk = ~clk;

  conv_mac_ctrl #(
    .KSIZE(KSIZE), .IN_W(IN_W), .MAX_CIN(MAX_CIN), .FA_W(FA_W), .WA_W(WA_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cin(cfg_cin),
    .busy(busy), .done(done), .fmap_addr(fmap_addr), .wgt_addr(wgt_addr),
    .mac_rstn(mac_rstn), .mac_en(mac_en), .mac_only_add(mac_only_add),
    .mac_dout(mac_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr)
  );

  // SRAMs with 1-cycle read latency, and a MAC whose bias path is scaled by 2^8.
  logic [7:0] fmap_mem [0:4095];
  logic [7:0] wgt_mem  [0:255];
  logic [7:0] fmap_rdata, wgt_rdata;
  int         acc;

  always @(posedge clk) begin
    fmap_rdata <= fmap_mem[fmap_addr];
    wgt_rdata  <= wgt_mem[wgt_addr];
    if (!mac_rstn) acc <= 0;
    else if (mac_en) acc <= mac_only_add ? acc + (int'(wgt_rdata) << 8)
                                         : acc + int'(fmap_rdata) * int'(wgt_rdata);
  end
  assign mac_dout = ((acc >>> 8) > 255) ? 8'hFF : 8'(acc >>> 8);

  // Observation log, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int clr_cnt, tap_i, mon_px, wr_n, done_cnt, done_cyc, en_total;
  int en_cnt [0:7], en_last [0:7], oa_cnt [0:7], oa_pos [0:7];
  int wr_data [0:7], wr_addr [0:7], wr_cyc [0:7];
  logic [FA_W-1:0] cap_fa [0:7][0:63];
  logic [WA_W-1:0] cap_wa [0:7][0:63];

  always @(negedge clk) begin
    if (mac_en) en_total = en_total + 1;
    if (rst) begin
      clr_cnt = 0; tap_i = -1; wr_n = 0; done_cnt = 0;
    end else begin
      if (!mac_rstn) begin
        if (clr_cnt < 8) begin
          en_cnt[clr_cnt] = 0; oa_cnt[clr_cnt] = 0;
          en_last[clr_cnt] = -1; oa_pos[clr_cnt] = -1;
        end
        clr_cnt = clr_cnt + 1;
        tap_i   = 0;
      end else if (tap_i >= 0) begin
        mon_px = clr_cnt - 1;
        if (mon_px < 8 && tap_i < 64) begin
          cap_fa[mon_px][tap_i] = fmap_addr;
          cap_wa[mon_px][tap_i] = wgt_addr;
          if (mac_en) begin en_cnt[mon_px] = en_cnt[mon_px] + 1; en_last[mon_px] = tap_i; end
          if (mac_only_add) begin oa_cnt[mon_px] = oa_cnt[mon_px] + 1; oa_pos[mon_px] = tap_i; end
        end
        tap_i = tap_i + 1;
      end
      if (out_valid && out_ready && wr_n < 8) begin
        wr_data[wr_n] = int'(out_data);
        wr_addr[wr_n] = int'(out_addr);
        wr_cyc[wr_n]  = cyc;
        wr_n = wr_n + 1;
      end
      if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; cfg_cin = 5'd1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] cin);
    @(posedge clk); #1;
    start = 1'b1; cfg_cin = cin;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_mem(input bit ramp, input logic [7:0] w, input logic [7:0] bias);
    for (int i = 0; i < 4096; i++) fmap_mem[i] = ramp ? 8'(i % 8) : 8'd16;
    for (int i = 0; i < 256; i++) wgt_mem[i] = w;
    wgt_mem[0] = bias;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(posedge clk); n++; end
    check_eq({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
  endtask

  initial begin
    int n, d0, a0, e0, vhi, dstab, astab;
    rst = 1'b1; start = 1'b0; cfg_cin = 5'd1; out_ready = 1'b1;
    fill_mem(1'b0, 8'd16, 8'd0);

    // Reset values and mac_rstn held low during reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_mac_en", 32'(mac_en), 32'd0);
    check_eq("rst_only_add", 32'(mac_only_add), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_fmap_addr", 32'(fmap_addr), 32'd0);
    check_eq("rst_wgt_addr", 32'(wgt_addr), 32'd0);
    check_eq("rst_out_addr", 32'(out_addr), 32'd0);
    check_eq("rst_mac_rstn", 32'(mac_rstn), 32'd0);

    // 1: constant fmap/weights 16, bias 0 -> 9 per pixel, 13-cycle period.
    apply_reset();
    fill_mem(1'b0, 8'd16, 8'd0);
    pulse_start(5'd1);
    wait_done("t1");
    check_eq("t1_writes", 32'(wr_n), 32'd4);
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("t1_data%0d", p), 32'(wr_data[p]), 32'd9);
      check_eq($sformatf("t1_addr%0d", p), 32'(wr_addr[p]), 32'(p));
      check_eq($sformatf("t1_en_cnt%0d", p), 32'(en_cnt[p]), 32'd10);
      if (p > 0) check_eq($sformatf("t1_period%0d", p), 32'(wr_cyc[p] - wr_cyc[p-1]), 32'd13);
    end
    check_eq("t1_done_lat", 32'(done_cyc - wr_cyc[3]), 32'd1);
    check_eq("t1_done_once", 32'(done_cnt), 32'd1);

    // 2: bias 2 -> 11; only_add exactly once, in the cycle after CLR.
    apply_reset();
    fill_mem(1'b0, 8'd16, 8'd2);
    pulse_start(5'd1);
    wait_done("t2");
    check_eq("t2_writes", 32'(wr_n), 32'd4);
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("t2_data%0d", p), 32'(wr_data[p]), 32'd11);
      check_eq($sformatf("t2_oa_cnt%0d", p), 32'(oa_cnt[p]), 32'd1);
      check_eq($sformatf("t2_oa_pos%0d", p), 32'(oa_pos[p]), 32'd0);
    end

    // 3: cin=2 ramp fmap; address sequence of pixel (1,1).
    apply_reset();
    fill_mem(1'b1, 8'd1, 8'd0);
    pulse_start(5'd2);
    wait_done("t3");
    check_eq("t3_first_addr", 32'(cap_fa[3][0]), 32'd5);
    for (int ci = 0; ci < 2; ci++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          check_eq($sformatf("t3_fa_c%0d_y%0d_x%0d", ci, ky, kx),
                   32'(cap_fa[3][ci*9 + ky*3 + kx]),
                   32'(ci*16 + (1 + ky)*4 + 1 + kx));
          check_eq($sformatf("t3_wa_c%0d_y%0d_x%0d", ci, ky, kx),
                   32'(cap_wa[3][ci*9 + ky*3 + kx]), 32'(1 + ci*9 + ky*3 + kx));
        end
    check_eq("t3_en_cnt", 32'(en_cnt[3]), 32'd19);
    check_eq("t3_en_last", 32'(en_last[3]), 32'd18);
    check_eq("t3_pix0_addr", 32'(cap_fa[0][0]), 32'd0);

    // 4: out_ready low for 10 cycles at pixel 2.
    apply_reset();
    fill_mem(1'b0, 8'd16, 8'd0);
    pulse_start(5'd1);
    n = 0;
    while (wr_n < 2 && n < 500) begin @(posedge clk); n++; end
    check_eq("t4_two_writes", 32'(wr_n >= 2), 32'd1);
    @(posedge clk); #1 out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    d0 = int'(out_data); a0 = int'(out_addr); e0 = en_total;
    vhi = 0; dstab = 0; astab = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) vhi++;
      if (int'(out_data) == d0) dstab++;
      if (int'(out_addr) == a0) astab++;
    end
    check_eq("t4_valid_held", 32'(vhi), 32'd10);
    check_eq("t4_data_stable", 32'(dstab), 32'd10);
    check_eq("t4_addr_stable", 32'(astab), 32'd10);
    check_eq("t4_stall_addr", 32'(a0), 32'd2);
    check_eq("t4_stall_data", 32'(d0), 32'd9);
    check_eq("t4_no_mac_en", 32'(en_total - e0), 32'd0);
    check_eq("t4_writes_during_stall", 32'(wr_n), 32'd2);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done("t4");
    check_eq("t4_writes", 32'(wr_n), 32'd4);
    check_eq("t4_addr2", 32'(wr_addr[2]), 32'd2);
    check_eq("t4_data3", 32'(wr_data[3]), 32'd9);

    // 5: reset during MAC of pixel 1, then a fresh run.
    apply_reset();
    fill_mem(1'b0, 8'd16, 8'd0);
    pulse_start(5'd1);
    n = 0;
    while (clr_cnt < 2 && n < 500) begin @(posedge clk); n++; end
    check_eq("t5_pix1_reached", 32'(clr_cnt >= 2), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("t5_mac_rstn_low", 32'(mac_rstn), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_out_valid", 32'(out_valid), 32'd0);
    check_eq("t5_mac_en", 32'(mac_en), 32'd0);
    check_eq("t5_out_addr", 32'(out_addr), 32'd0);
    pulse_start(5'd1);
    wait_done("t5");
    check_eq("t5_writes", 32'(wr_n), 32'd4);
    check_eq("t5_addr0", 32'(wr_addr[0]), 32'd0);
    check_eq("t5_data0", 32'(wr_data[0]), 32'd9);

    // 6: cfg_cin=0 runs as cin=1; a start while busy is ignored.
    apply_reset();
    fill_mem(1'b0, 8'd16, 8'd0);
    pulse_start(5'd0);
    repeat (5) @(posedge clk);
    pulse_start(5'd2);
    wait_done("t6");
    check_eq("t6_writes", 32'(wr_n), 32'd4);
    check_eq("t6_data0", 32'(wr_data[0]), 32'd9);
    check_eq("t6_en_cnt0", 32'(en_cnt[0]), 32'd10);
    check_eq("t6_period", 32'(wr_cyc[1] - wr_cyc[0]), 32'd13);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_eq("t6_single_done", 32'(done_cnt), 32'd1);
    check_eq("t6_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_mac_ctrl.md
Name: conv_mac_ctrl

Overview:
- Sequences one mac instance to compute a single-output-channel 2D convolution: valid padding, stride 1, square KSIZE x KSIZE kernel, cfg_cin input channels.
- Per output pixel: clears the accumulator, adds the bias through mac only_add, streams all taps, then presents the quantized result on a ready/valid write port.
- Sits between the feature-map/weight SRAMs (1-cycle read latency), the mac, and the output buffer.

Parameters:
- KSIZE, 3, kernel height and width.
- IN_W, 8, input feature map height and width (square).
- MAX_CIN, 16, largest supported channel count; sets address widths.
- FA_W, 12, fmap address width; must satisfy 2^FA_W >= MAX_CIN*IN_W*IN_W.
- WA_W, 8, weight address width; must satisfy 2^WA_W >= MAX_CIN*KSIZE*KSIZE+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  1-cycle pulse; accepted only in IDLE.
- cfg_cin  in  5  input channel count; sampled on accepted start; 0 treated as 1.
- busy  out  1  high from start acceptance until done.
- done  out  1  1-cycle pulse after the last pixel is written.
- fmap_addr  out  FA_W  fmap SRAM read address.
- wgt_addr  out  WA_W  weight SRAM read address; address 0 = bias, taps from address 1.
- mac_rstn  out  1  to mac rstn; low = clear the accumulator.
- mac_en  out  1  to mac enable.
- mac_only_add  out  1  to mac only_add; the top-level mux routes wgt_rdata to din_a while this is high.
- mac_dout  in  8  mac quantized output.
- out_valid  out  1  result valid.
- out_ready  in  1  output sink ready.
- out_data  out  8  captured result.
- out_addr  out  FA_W  pixel index oy*OUT_W+ox, with OUT_W = IN_W-KSIZE+1.

Behaviour:
- Reset values: busy=0, done=0, mac_en=0, mac_only_add=0, out_valid=0, out_data=0, fmap_addr=0, wgt_addr=0, out_addr=0.
- mac_rstn = ~(rst | clr_strobe); it is held low during rst.
- Reset asserted mid-operation returns the block to IDLE and drops any pending output.
- States:
  - IDLE: on start go to CLR with oy=ox=0.
  - CLR (1 cycle): clr_strobe=1; wgt_addr=0 issued (bias).
  - MAC (N = cin*KSIZE*KSIZE cycles): issue one tap per cycle. Loop order is kx fastest, then ky, then ci.
    - fmap_addr = ci*IN_W*IN_W + (oy+ky)*IN_W + ox+kx.
    - wgt_addr = 1 + ci*KSIZE*KSIZE + ky*KSIZE + kx.
    - Addresses are computed incrementally; no multipliers.
  - DRAIN (1 cycle): no issue.
  - SETTLE (1 cycle): out_data <= mac_dout at the cycle end.
  - WRITE: out_valid=1 until out_ready is sampled high, then advance the pixel.
    - Next pixel: ox wraps at OUT_W and increments oy.
    - Exit to CLR, or to DONE after pixel OUT_W*OUT_W-1.
  - DONE (1 cycle): done=1, busy=0 from the next cycle, then IDLE.
- Data alignment: mac_en and mac_only_add are issue strobes delayed 1 cycle to match SRAM latency.
  - Bias add: mac_en=1, mac_only_add=1 in the first MAC cycle.
  - Tap t: mac_en=1 in cycle t+2 after CLR, so the last tap lands in DRAIN.
- Pixel period = N+4 cycles with out_ready high; out_ready low stalls in WRITE indefinitely with out_data/out_addr stable.
- start while busy is ignored. Accumulation width and saturation are owned by mac; the controller only sequences it.

Decomposition:
- Package conv_ctrl_pkg holds:
  - the state enum (IDLE, CLR, MAC, DRAIN, SETTLE, WRITE, DONE);
  - the OUT_W and N derivation functions;
  - the bias weight address constant (0).
- One sub-module, conv_addr_gen: a kx/ky/ci/ox/oy counter nest with incremental fmap_addr, wgt_addr and out_addr.
  - Inputs: load, step, next_pixel.
  - Outputs: last_tap, last_pixel.

Test Plan:
1. IN_W=4, cin=1, fmap all 16, weights all 16, bias 0 -> 4 writes out_data=9 at out_addr 0..3, 13 cycles apart; done 1 cycle after the 4th handshake.
2. Same as 1 with bias=2 -> out_data=11; mac_only_add high for exactly 1 cycle per pixel, in the cycle after CLR.
3. cin=2, fmap ramp (addr mod 8), weights 1 -> the fmap_addr sequence for pixel (1,1) matches the ci/ky/kx formula; the first address is 5, then 6, 7, 9, ...
4. out_ready held low 10 cycles at pixel 2 -> out_valid stays high, out_data/out_addr stable, no mac_en pulses; resumes on ready.
5. rst pulsed during MAC of pixel 1 -> next cycle IDLE, mac_rstn low during rst, out_valid=0, busy=0; a fresh start restarts at out_addr 0.
6. start pulsed while busy and cfg_cin=0 -> the second start is ignored; cfg_cin=0 runs as cin=1 (N=9).
